// File: rtl/dma_int_status_arbiter.sv
// N-source DMA status arbiter (fixed or round-robin) into one registered valid/ready stage.
// One cycle request-to-valid; the stage refills while draining and holds steady while out_ready is low.
module dma_int_status_arbiter #(
    parameter int NUM_SRC           = 4,
    parameter int SRC_ID_WIDTH      = 2,
    parameter int NUM_INT_BDS_WIDTH = 2,
    parameter int STA_WIDTH         = 4,
    parameter int ARB_MODE          = 1
) (
    input  logic                                 clock,
    input  logic                                 resetn,
    input  logic [NUM_SRC-1:0]                   src_valid,
    input  logic [NUM_SRC*STA_WIDTH-1:0]         src_status,
    input  logic [NUM_SRC*NUM_INT_BDS_WIDTH-1:0] src_intDscrptrNum,
    input  logic [NUM_SRC-1:0]                   src_extDscrptr,
    input  logic [NUM_SRC-1:0]                   src_strDscrptr,
    input  logic [NUM_SRC*32-1:0]                src_extDscrptrAddr,
    output logic [NUM_SRC-1:0]                   src_ack,
    input  logic                                 out_ready,
    output logic                                 out_valid,
    output logic [STA_WIDTH-1:0]                 out_status,
    output logic [NUM_INT_BDS_WIDTH-1:0]         out_intDscrptrNum,
    output logic                                 out_extDscrptr,
    output logic                                 out_strDscrptr,
    output logic [31:0]                          out_extDscrptrAddr,
    output logic [SRC_ID_WIDTH-1:0]              out_srcId
);

    localparam int W = SRC_ID_WIDTH;

    logic [W-1:0]                 rrPtr;
    logic [W-1:0]                 rrPtrNext;
    logic [W-1:0]                 lowIdx;
    logic [W-1:0]                 hiIdx;
    logic                         anyHi;
    logic [W-1:0]                 winner;
    logic                         load;
    logic [STA_WIDTH-1:0]         selStatus;
    logic [NUM_INT_BDS_WIDTH-1:0] selNum;
    logic                         selExt;
    logic                         selStr;
    logic [31:0]                  selAddr;

    // Descending scans leave the lowest matching index; hiIdx is the first requester at or above rrPtr.
    always_comb begin
        lowIdx = '0;
        hiIdx  = '0;
        anyHi  = 1'b0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (src_valid[i]) begin
                lowIdx = W'(i);
                if (W'(i) >= rrPtr) begin
                    hiIdx = W'(i);
                    anyHi = 1'b1;
                end
            end
        end
    end

    assign winner    = ((ARB_MODE == 1) && anyHi) ? hiIdx : lowIdx;
    assign rrPtrNext = (winner == W'(NUM_SRC - 1)) ? '0 : winner + W'(1);

    // A held event is discarded during reset, so no grant may be issued while resetn is low.
    assign load = resetn & (|src_valid) & (~out_valid | out_ready);

    always_comb begin
        src_ack   = '0;
        selStatus = '0;
        selNum    = '0;
        selExt    = 1'b0;
        selStr    = 1'b0;
        selAddr   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (winner == W'(i)) begin
                src_ack[i] = load;
                selStatus  = src_status[i*STA_WIDTH +: STA_WIDTH];
                selNum     = src_intDscrptrNum[i*NUM_INT_BDS_WIDTH +: NUM_INT_BDS_WIDTH];
                selExt     = src_extDscrptr[i];
                selStr     = src_strDscrptr[i];
                selAddr    = src_extDscrptrAddr[i*32 +: 32];
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            out_valid          <= 1'b0;
            out_status         <= '0;
            out_intDscrptrNum  <= '0;
            out_extDscrptr     <= 1'b0;
            out_strDscrptr     <= 1'b0;
            out_extDscrptrAddr <= '0;
            out_srcId          <= '0;
            rrPtr              <= '0;
        end else if (load) begin
            out_valid          <= 1'b1;
            out_status         <= selStatus;
            out_intDscrptrNum  <= selNum;
            out_extDscrptr     <= selExt;
            out_strDscrptr     <= selStr;
            out_extDscrptrAddr <= selAddr;
            out_srcId          <= winner;
            if (ARB_MODE == 1) begin
                rrPtr <= rrPtrNext;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dma_int_status_arbiter.sv
// Scoreboarded bench: one round-robin and one fixed-priority arbiter driven by directed vectors.
module tb_dma_int_status_arbiter;

    typedef struct packed {
        logic [1:0]  id;
        logic [3:0]  st;
        logic [1:0]  num;
        logic        ext;
        logic        str;
        logic [31:0] addr;
    } ev_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        resetn;
    logic [3:0]  rrValid, fxValid, rrAck, fxAck;
    logic        rrReady, fxReady;
    logic [3:0]  stArr[4];
    logic [1:0]  numArr[4];
    logic [31:0] addrArr[4];
    logic [3:0]  extBits, strBits;
    logic [15:0] srcStatus;
    logic [7:0]  srcNum;
    logic [127:0] srcAddr;

    logic        rrOutValid, fxOutValid, rrOutExt, fxOutExt, rrOutStr, fxOutStr;
    logic [3:0]  rrOutStatus, fxOutStatus;
    logic [1:0]  rrOutNum, fxOutNum, rrOutId, fxOutId;
    logic [31:0] rrOutAddr, fxOutAddr;

    ev_t rrQ[$];
    ev_t fxQ[$];
    int  checks = 0;
    int  failures = 0;

    always_comb begin
        srcStatus = '0;
        srcNum    = '0;
        srcAddr   = '0;
        for (int i = 0; i < 4; i++) begin
            srcStatus[i*4 +: 4]  = stArr[i];
            srcNum[i*2 +: 2]     = numArr[i];
            srcAddr[i*32 +: 32]  = addrArr[i];
        end
    end

    dma_int_status_arbiter #(.ARB_MODE(1)) dut (
        .clock(clock), .resetn(resetn),
        .src_valid(rrValid), .src_status(srcStatus), .src_intDscrptrNum(srcNum),
        .src_extDscrptr(extBits), .src_strDscrptr(strBits), .src_extDscrptrAddr(srcAddr),
        .src_ack(rrAck), .out_ready(rrReady), .out_valid(rrOutValid),
        .out_status(rrOutStatus), .out_intDscrptrNum(rrOutNum),
        .out_extDscrptr(rrOutExt), .out_strDscrptr(rrOutStr),
        .out_extDscrptrAddr(rrOutAddr), .out_srcId(rrOutId)
    );

    dma_int_status_arbiter #(.ARB_MODE(0)) dutFx (
        .clock(clock), .resetn(resetn),
        .src_valid(fxValid), .src_status(srcStatus), .src_intDscrptrNum(srcNum),
        .src_extDscrptr(extBits), .src_strDscrptr(strBits), .src_extDscrptrAddr(srcAddr),
        .src_ack(fxAck), .out_ready(fxReady), .out_valid(fxOutValid),
        .out_status(fxOutStatus), .out_intDscrptrNum(fxOutNum),
        .out_extDscrptr(fxOutExt), .out_strDscrptr(fxOutStr),
        .out_extDscrptrAddr(fxOutAddr), .out_srcId(fxOutId)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic ev_t mkExp(input int i);
        ev_t e;
        e.id   = 2'(i);
        e.st   = stArr[i];
        e.num  = numArr[i];
        e.ext  = extBits[i];
        e.str  = strBits[i];
        e.addr = addrArr[i];
        return e;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Monitors: compare every event accepted downstream against the head of its queue.
    always @(negedge clock) begin
        ev_t act;
        if (resetn && rrOutValid && rrReady) begin
            act = {rrOutId, rrOutStatus, rrOutNum, rrOutExt, rrOutStr, rrOutAddr};
            if (rrQ.size() == 0) chk("rr_unexpected_event", 64'(act), 64'h0);
            else chk("rr_event", 64'(act), 64'(rrQ.pop_front()));
        end
    end

    always @(negedge clock) begin
        ev_t act;
        if (resetn && fxOutValid && fxReady) begin
            act = {fxOutId, fxOutStatus, fxOutNum, fxOutExt, fxOutStr, fxOutAddr};
            if (fxQ.size() == 0) chk("fx_unexpected_event", 64'(act), 64'h0);
            else chk("fx_event", 64'(act), 64'(fxQ.pop_front()));
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog_timeout at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        stArr   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        numArr  = '{2'd3, 2'd2, 2'd1, 2'd0};
        addrArr = '{32'h1000_0000, 32'h1000_0010, 32'h1000_0040, 32'h1000_0060};
        extBits = 4'b0101;
        strBits = 4'b0011;
        rrValid = '0;
        fxValid = '0;
        rrReady = 1'b0;
        fxReady = 1'b0;
        resetn  = 1'b1;
        #1 resetn = 1'b0;
        #11;
        chk("reset_out_valid", 64'(rrOutValid), 64'h0);
        chk("reset_out_status", 64'(rrOutStatus), 64'h0);
        chk("reset_out_addr", 64'(rrOutAddr), 64'h0);
        chk("reset_out_srcId", 64'(rrOutId), 64'h0);
        chk("reset_fx_out_valid", 64'(fxOutValid), 64'h0);
        @(negedge clock);
        resetn = 1'b1;

        // Round-robin rotation with all four sources requesting.
        step();
        rrValid = 4'b1111;
        rrReady = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1 chk("rr_rotate_ack", 64'(rrAck), 64'(4'b0001 << (k % 4)));
            rrQ.push_back(mkExp(k % 4));
            step();
        end
        rrValid = '0;
        #1 chk("rr_idle_ack", 64'(rrAck), 64'h0);

        // Fixed priority: source 1 always beats source 3.
        step();
        fxValid = 4'b1010;
        fxReady = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1 chk("fx_ack", 64'(fxAck), 64'h2);
            fxQ.push_back(mkExp(1));
            step();
        end
        fxValid = '0;

        // Single request into an empty stage, then drain with no refill.
        stArr[2] = 4'b0001;
        step();
        rrValid = 4'b0100;
        rrReady = 1'b1;
        #1 chk("single_ack", 64'(rrAck), 64'h4);
        rrQ.push_back('{id: 2'd2, st: 4'b0001, num: 2'd1, ext: 1'b1, str: 1'b0, addr: 32'h1000_0040});
        step();
        rrValid = '0;
        #1 chk("single_ack_clear", 64'(rrAck), 64'h0);
        chk("single_out_valid", 64'(rrOutValid), 64'h1);
        chk("single_out_srcId", 64'(rrOutId), 64'h2);
        step();
        chk("drain_out_valid", 64'(rrOutValid), 64'h0);
        chk("drain_addr_held", 64'(rrOutAddr), 64'h1000_0040);
        chk("drain_status_held", 64'(rrOutStatus), 64'h1);

        // Back-pressure: stall five cycles, then release and refill with no bubble.
        step();
        rrValid = 4'b0001;
        rrReady = 1'b1;
        #1 chk("bp_first_ack", 64'(rrAck), 64'h1);
        rrQ.push_back(mkExp(0));
        step();
        rrReady = 1'b0;
        addrArr[0] = 32'hA000_0000;
        for (int c = 0; c < 5; c++) begin
            #1 chk("bp_stall_ack", 64'(rrAck), 64'h0);
            chk("bp_stall_valid", 64'(rrOutValid), 64'h1);
            chk("bp_stall_addr", 64'(rrOutAddr), 64'h1000_0000);
            chk("bp_stall_status", 64'(rrOutStatus), 64'h1);
            step();
        end
        rrReady = 1'b1;
        #1 chk("bp_release_ack", 64'(rrAck), 64'h1);
        rrQ.push_back(mkExp(0));
        step();
        rrReady = 1'b0;
        rrValid = '0;
        #1 chk("bp_nobubble_valid", 64'(rrOutValid), 64'h1);
        chk("bp_nobubble_addr", 64'(rrOutAddr), 64'hA000_0000);

        // Asynchronous reset while an event is stalled.
        #2 resetn = 1'b0;
        #1 chk("arst_out_valid", 64'(rrOutValid), 64'h0);
        chk("arst_out_addr", 64'(rrOutAddr), 64'h0);
        chk("arst_out_status", 64'(rrOutStatus), 64'h0);
        chk("arst_out_srcId", 64'(rrOutId), 64'h0);
        if (rrQ.size() > 0) void'(rrQ.pop_back());
        @(negedge clock);
        @(negedge clock);
        resetn = 1'b1;
        step();
        rrValid = 4'b1111;
        rrReady = 1'b1;
        #1 chk("post_reset_ack", 64'(rrAck), 64'h1);
        rrQ.push_back(mkExp(0));
        step();
        rrValid = '0;
        repeat (3) step();

        chk("rr_queue_empty", 64'(rrQ.size()), 64'h0);
        chk("fx_queue_empty", 64'(fxQ.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
